nf_req_arb: RTL and testbench
=============================

Name: nf_req_arb

Overview:
- Round-robin arbiter that shares one req/req_ack memory-bus slave port among several masters.
- Typical use: the core-side port of nf_ahb_top, shared between the nf_cpu_cc cross-connect port and a second master such as a debug or DMA engine.
- Grants one transaction at a time, holds the grant until the slave acknowledges, and aborts with an error if the slave does not acknowledge within a timeout.

Parameters:
- mst_c, 2, number of masters (2..8); master 0 has the highest initial priority.
- tmo_w, 8, width of the timeout counter.
- tmo_v, 255, number of BUSY cycles without ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- addr_m  in  [mst_c-1:0][31:0]  master addresses.
- wd_m  in  [mst_c-1:0][31:0]  master write data.
- we_m  in  [mst_c-1:0]  master write enables.
- req_m  in  [mst_c-1:0]  master requests.
- rd_m  out  [mst_c-1:0][31:0]  read data returned to each master.
- req_ack_m  out  [mst_c-1:0]  per-master acknowledge, one-cycle pulse.
- err_m  out  [mst_c-1:0]  per-master timeout error, qualified by req_ack_m.
- addr  out  32  slave address.
- wd  out  32  slave write data.
- we  out  1  slave write enable.
- req  out  1  slave request.
- rd  in  32  slave read data, valid while req_ack=1.
- req_ack  in  1  slave acknowledge.
- gnt  out  [mst_c-1:0]  one-hot current grant, for debug.

Behaviour:
- Bus protocol: a master holds req_m, addr_m, we_m and wd_m stable until it sees req_ack_m. Slave data rd is sampled only while req_ack=1.
- State machine:
  - Two states, IDLE and BUSY.
  - Registered state: gnt_idx, last_idx, tmo_cnt.
- Reset (resetn=0 at a clock edge):
  - state=IDLE, gnt=0, tmo_cnt=0, last_idx=mst_c-1, so master 0 wins first.
  - All outputs are 0 from that edge onward.
  - Reset mid-transaction abandons the transaction silently: no ack and no err to any master.
- IDLE:
  - req=0, we=0, addr=0, wd=0, and every req_ack_m, err_m and rd_m is 0.
  - If any req_m bit is set, pick the first requester scanning last_idx+1, last_idx+2, … modulo mst_c.
  - Register that pick as gnt_idx, clear tmo_cnt, and go to BUSY.
  - Grant latency is exactly one cycle: master request at edge N gives slave req=1 in the cycle after edge N+1.
- BUSY, slave-side outputs:
  - req=1.
  - addr, we and wd are driven combinationally from the master at gnt_idx.
  - gnt is one-hot at gnt_idx.
- BUSY, slave acknowledges (req_ack=1):
  - Same cycle, combinational: req_ack_m[gnt_idx]=1 and rd_m[gnt_idx]=rd.
  - Next edge: last_idx←gnt_idx, state→IDLE.
  - This forces one mandatory IDLE cycle between transactions, so the slave sees req drop for at least one cycle.
- BUSY, no ack:
  - tmo_cnt increments on each edge.
  - If tmo_v≠0 and tmo_cnt==tmo_v-1 with req_ack=0, then in that cycle req_ack_m[gnt_idx]=1, err_m[gnt_idx]=1 and rd_m[gnt_idx]=0.
  - Next edge: last_idx←gnt_idx, state→IDLE.
- Same-cycle ack and timeout: if req_ack and the timeout fire together, ack wins and err_m=0.
- Late slave ack: a slave ack arriving in IDLE is ignored and produces no master ack.
- Non-granted masters:
  - req_ack_m, err_m and rd_m are always 0.
  - Their requests wait with no starvation: worst-case wait is mst_c-1 transactions.
- Granted master drops req_m while BUSY (protocol violation):
  - The arbiter keeps req=1 until ack or timeout.
  - The ack is still delivered to that master.
- Simultaneous requests: resolved by round-robin order from last_idx. Fixed priority is never used after the first grant.
- Counter: tmo_cnt is tmo_w bits and saturates at all-ones. tmo_v must be less than 2^tmo_w; otherwise the behaviour is undefined.

Test Plan:
- Single master, zero-wait slave:
  - Stimulus: reset, then master 0 reads addr 0x0000_0010 and the slave returns 0xDEAD_BEEF with req_ack in the first BUSY cycle.
  - Required: slave req=1 exactly one cycle after master req, rd_m[0]=0xDEAD_BEEF with req_ack_m[0] for 1 cycle, err_m[0]=0, then 1 IDLE cycle.
- Contention:
  - Stimulus: masters 0 and 1 both request continuously, slave acks after 2 cycles.
  - Required: grant order 0,1,0,1; each master receives 1 ack per 2 transactions; gnt is never two-hot.
- Write passthrough:
  - Stimulus: master 1 writes we=1, addr=0x0000_0004, wd=0x1234_5678.
  - Required: slave sees exactly those values while req=1; master 0 signals do not leak onto the slave bus.
- Timeout:
  - Stimulus: tmo_v=4, slave never acks.
  - Required: in the 4th BUSY cycle, req_ack_m=1, err_m=1, rd_m=0; then IDLE. A slave ack driven 2 cycles later produces no master ack.
- Ack/timeout collision:
  - Stimulus: tmo_v=4, slave acks in the 4th BUSY cycle.
  - Required: normal ack with err_m=0 and rd forwarded.
- Reset mid-transaction:
  - Stimulus: assert resetn=0 for one edge during BUSY.
  - Required: req=0 and gnt=0 after that edge, no ack to the master; the next simultaneous 0/1 request grants master 0 first.

Source files
------------

// File: rtl/nf_req_arb.sv
// Round-robin arbiter sharing one req/req_ack slave port among mst_c masters.
// Latency: grant one cycle after a request; ack/rd forwarded combinationally in the acked cycle.
// Backpressure: a granted transaction is held until slave ack or timeout; others wait in RR order.
module nf_req_arb #(
  parameter int mst_c = 2,
  parameter int tmo_w = 8,
  parameter int tmo_v = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [mst_c-1:0][31:0] addr_m,
  input  logic [mst_c-1:0][31:0] wd_m,
  input  logic [mst_c-1:0]       we_m,
  input  logic [mst_c-1:0]       req_m,
  output logic [mst_c-1:0][31:0] rd_m,
  output logic [mst_c-1:0]       req_ack_m,
  output logic [mst_c-1:0]       err_m,
  output logic [31:0]            addr,
  output logic [31:0]            wd,
  output logic                   we,
  output logic                   req,
  input  logic [31:0]            rd,
  input  logic                   req_ack,
  output logic [mst_c-1:0]       gnt
);

  localparam int               idx_w    = (mst_c > 1) ? $clog2(mst_c) : 1;
  localparam logic [idx_w-1:0] last_rst = idx_w'(mst_c - 1);
  localparam bit               tmo_en   = (tmo_v != 0);
  // Value of tmo_cnt during the last BUSY cycle allowed before abort.
  localparam logic [tmo_w-1:0] tmo_last = tmo_en ? tmo_w'(tmo_v - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [idx_w-1:0] gnt_idx, gnt_idx_nxt;
  logic [idx_w-1:0] last_idx, last_idx_nxt;
  logic [tmo_w-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [idx_w-1:0] pick_idx, cand;
  logic             pick_vld;
  logic             tmo_hit;

  // Round-robin pick: first requester after last_idx; scanning from the far end
  // so the nearest requester is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_idx;
    cand     = '0;
    for (int k = mst_c; k >= 1; k--) begin
      cand = idx_w'((int'(last_idx) + k) % mst_c);
      if (req_m[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Abort fires only when the slave stays silent in the final allowed cycle; an ack wins.
  always_comb begin
    tmo_hit = tmo_en && (state == BUSY) && !req_ack && (tmo_cnt == tmo_last);
  end

  // Next-state logic and all outputs; IDLE drives everything to zero.
  always_comb begin
    state_nxt    = state;
    gnt_idx_nxt  = gnt_idx;
    last_idx_nxt = last_idx;
    tmo_cnt_nxt  = tmo_cnt;
    req          = 1'b0;
    we           = 1'b0;
    addr         = '0;
    wd           = '0;
    gnt          = '0;
    req_ack_m    = '0;
    err_m        = '0;
    rd_m         = '0;
    case (state)
      IDLE: begin
        // A late slave ack here is simply ignored.
        if (pick_vld) begin
          gnt_idx_nxt = pick_idx;
          tmo_cnt_nxt = '0;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        // Grant is held even if the master withdraws its request mid-transaction.
        req          = 1'b1;
        addr         = addr_m[gnt_idx];
        wd           = wd_m[gnt_idx];
        we           = we_m[gnt_idx];
        gnt[gnt_idx] = 1'b1;
        if (req_ack) begin
          req_ack_m[gnt_idx] = 1'b1;
          rd_m[gnt_idx]      = rd;
          last_idx_nxt       = gnt_idx;
          state_nxt          = IDLE;
        end else if (tmo_hit) begin
          req_ack_m[gnt_idx] = 1'b1;
          err_m[gnt_idx]     = 1'b1;
          last_idx_nxt       = gnt_idx;
          state_nxt          = IDLE;
        end else if (!(&tmo_cnt)) begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end
    endcase
  end

  // State register; reset leaves master 0 next in round-robin order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_idx <= last_rst;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      gnt_idx  <= gnt_idx_nxt;
      last_idx <= last_idx_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_nf_req_arb.sv
// Bench for nf_req_arb: directed scenarios plus randomized traffic vs a transaction-level model.
// Latency: outputs compared every cycle at the falling edge.
// Backpressure: random slave ack rates, including none, exercise waiting and timeouts.
module tb_nf_req_arb;
  localparam int M    = 3;
  localparam int TMOW = 8;
  localparam int TMO  = 4;

  logic                clk = 1'b0;
  logic                resetn;
  logic [M-1:0][31:0]  addr_m, wd_m, rd_m;
  logic [M-1:0]        we_m, req_m, req_ack_m, err_m, gnt;
  logic [31:0]         addr, wd, rd;
  logic                we, req, req_ack;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  nf_req_arb #(.mst_c(M), .tmo_w(TMOW), .tmo_v(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .addr_m(addr_m), .wd_m(wd_m), .we_m(we_m), .req_m(req_m),
    .rd_m(rd_m), .req_ack_m(req_ack_m), .err_m(err_m),
    .addr(addr), .wd(wd), .we(we), .req(req),
    .rd(rd), .req_ack(req_ack), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: who owns the bus (-1 = nobody), how long it has waited,
  // and who was served last.
  int m_cur = -1, m_age = 0, m_last = M - 1;

  always @(posedge clk) begin
    bit found;
    found = 1'b0;
    if (!resetn) begin
      m_cur = -1; m_age = 0; m_last = M - 1;
    end else if (m_cur < 0) begin
      for (int k = 1; k <= M; k++) begin
        if (!found && req_m[(m_last + k) % M]) begin
          m_cur = (m_last + k) % M; m_age = 0; found = 1'b1;
        end
      end
    end else if (req_ack || (TMO != 0 && m_age == TMO - 1)) begin
      m_last = m_cur; m_cur = -1;
    end else begin
      m_age++;
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    logic              e_req, e_we;
    logic [31:0]       e_addr, e_wd;
    logic [M-1:0]      e_gnt, e_ack, e_err;
    logic [M-1:0][31:0] e_rd;
    if (chk_en) begin
      e_req = 0; e_we = 0; e_addr = '0; e_wd = '0;
      e_gnt = '0; e_ack = '0; e_err = '0; e_rd = '0;
      if (m_cur >= 0) begin
        e_req = 1; e_addr = addr_m[m_cur]; e_wd = wd_m[m_cur]; e_we = we_m[m_cur];
        e_gnt[m_cur] = 1'b1;
        if (req_ack) begin
          e_ack[m_cur] = 1'b1; e_rd[m_cur] = rd;
        end else if (TMO != 0 && m_age == TMO - 1) begin
          e_ack[m_cur] = 1'b1; e_err[m_cur] = 1'b1;
        end
      end
      chk("m_req", 128'(req), 128'(e_req));
      chk("m_we", 128'(we), 128'(e_we));
      chk("m_addr", 128'(addr), 128'(e_addr));
      chk("m_wd", 128'(wd), 128'(e_wd));
      chk("m_gnt", 128'(gnt), 128'(e_gnt));
      chk("m_ack", 128'(req_ack_m), 128'(e_ack));
      chk("m_err", 128'(err_m), 128'(e_err));
      chk("m_rd", 128'(rd_m), 128'(e_rd));
    end
  end

  task automatic do_reset();
    resetn = 0; req_m = '0; req_ack = 0; rd = '0;
    tick(); tick();
    resetn = 1; chk_en = 1'b1;
    #3;
    chk("rst_req", 128'(req), 128'd0);
    chk("rst_gnt", 128'(gnt), 128'd0);
    chk("rst_ack", 128'(req_ack_m), 128'd0);
  endtask

  int          order[4];
  int          nacks, bcnt, who;
  int          ackp;
  logic [M-1:0] pend, ackd;

  initial begin
    resetn = 0; addr_m = '0; wd_m = '0; we_m = '0; req_m = '0; rd = '0; req_ack = 0;

    // Single master, zero-wait slave, then back-to-back request shows the idle gap.
    do_reset();
    addr_m[0] = 32'h0000_0010; we_m[0] = 1'b0; req_m[0] = 1'b1;
    #3 chk("t1_req_idle", 128'(req), 128'd0);
    tick();
    req_ack = 1; rd = 32'hDEAD_BEEF;
    #3;
    chk("t1_req_busy", 128'(req), 128'd1);
    chk("t1_addr", 128'(addr), 128'h10);
    chk("t1_gnt", 128'(gnt), 128'b001);
    chk("t1_ack", 128'(req_ack_m), 128'b001);
    chk("t1_err", 128'(err_m), 128'd0);
    chk("t1_rd", 128'(rd_m[0]), 128'hDEAD_BEEF);
    tick();
    req_ack = 0; rd = '0;
    #3;
    chk("t1_gap_req", 128'(req), 128'd0);
    chk("t1_gap_ack", 128'(req_ack_m), 128'd0);
    tick();
    #3 chk("t1_again", 128'(req), 128'd1);
    req_ack = 1;
    tick();
    req_ack = 0; req_m = '0;

    // Contention between masters 0 and 1, slave acks in the second BUSY cycle.
    do_reset();
    req_m = 3'b011; bcnt = 0; nacks = 0;
    for (int c = 0; c < 60 && nacks < 4; c++) begin
      tick();
      if (req) bcnt++; else bcnt = 0;
      req_ack = (bcnt == 2); rd = $urandom;
      #3;
      chk("t2_onehot", 128'($onehot0(gnt)), 128'd1);
      if (req_ack_m != '0) begin
        who = -1;
        for (int i = 0; i < M; i++) if (req_ack_m[i]) who = i;
        order[nacks] = who; nacks++;
      end
    end
    tick();
    req_m = '0; req_ack = 0;
    chk("t2_nacks", 128'(nacks), 128'd4);
    chk("t2_order0", 128'(order[0]), 128'd0);
    chk("t2_order1", 128'(order[1]), 128'd1);
    chk("t2_order2", 128'(order[2]), 128'd0);
    chk("t2_order3", 128'(order[3]), 128'd1);

    // Write passthrough from master 1 with idle master 0 carrying junk.
    do_reset();
    addr_m[0] = 32'hFFFF_FFFF; wd_m[0] = 32'hAAAA_AAAA; we_m[0] = 1'b1;
    addr_m[1] = 32'h0000_0004; wd_m[1] = 32'h1234_5678; we_m[1] = 1'b1;
    req_m = 3'b010;
    tick();
    #3;
    chk("t3_addr", 128'(addr), 128'h4);
    chk("t3_wd", 128'(wd), 128'h1234_5678);
    chk("t3_we", 128'(we), 128'd1);
    chk("t3_gnt", 128'(gnt), 128'b010);
    req_ack = 1;
    #1 chk("t3_ack", 128'(req_ack_m), 128'b010);
    tick();
    req_ack = 0; req_m = '0;

    // Timeout on master 2; late slave ack afterwards is ignored.
    do_reset();
    addr_m[2] = 32'h0000_0100; req_m = 3'b100; rd = 32'h5555_5555;
    tick();
    for (int c = 1; c <= 4; c++) begin
      #3;
      if (c < 4) chk("t4_noack", 128'(req_ack_m), 128'd0);
      else begin
        chk("t4_ack", 128'(req_ack_m), 128'b100);
        chk("t4_err", 128'(err_m), 128'b100);
        chk("t4_rd", 128'(rd_m), 128'd0);
      end
      tick();
    end
    req_m = '0;
    #3 chk("t4_idle", 128'(req), 128'd0);
    tick(); tick();
    req_ack = 1;
    #3;
    chk("t4_late_ack", 128'(req_ack_m), 128'd0);
    chk("t4_late_req", 128'(req), 128'd0);
    tick();
    req_ack = 0;

    // Ack and timeout in the same cycle: ack wins.
    do_reset();
    req_m = 3'b001;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin req_ack = 1; rd = 32'hCAFE_F00D; end
      #3;
      if (c == 4) begin
        chk("t5_ack", 128'(req_ack_m), 128'b001);
        chk("t5_err", 128'(err_m), 128'd0);
        chk("t5_rd", 128'(rd_m[0]), 128'hCAFE_F00D);
      end
      tick();
    end
    req_ack = 0; req_m = '0;

    // Reset in the middle of a transaction, then 0/1 race goes to master 0.
    do_reset();
    req_m = 3'b010;
    tick(); tick();
    resetn = 0;
    tick();
    resetn = 1; req_m = 3'b011;
    #3;
    chk("t6_req", 128'(req), 128'd0);
    chk("t6_gnt", 128'(gnt), 128'd0);
    chk("t6_ack", 128'(req_ack_m), 128'd0);
    tick();
    #3 chk("t6_first", 128'(gnt), 128'b001);
    req_ack = 1;
    tick();
    req_ack = 0; req_m = '0;

    // Randomized traffic with varying slave responsiveness and occasional resets.
    pend = '0; ackd = '0; ackp = 60;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!resetn) pend = '0;
      resetn = ($urandom % 250) != 0;
      case ((c / 500) % 4)
        0: ackp = 60;
        1: ackp = 25;
        2: ackp = 0;
        default: ackp = 90;
      endcase
      for (int i = 0; i < M; i++) begin
        if (ackd[i]) pend[i] = 1'b0;
        if (pend[i] && ($urandom % 400) == 0) pend[i] = 1'b0;
        if (!pend[i]) begin
          addr_m[i] = $urandom; wd_m[i] = $urandom; we_m[i] = $urandom % 2;
          if (($urandom % 3) == 0) pend[i] = 1'b1;
        end
      end
      req_m = pend;
      req_ack = ($urandom % 100) < ackp;
      rd = $urandom;
      #3 ackd = req_ack_m;
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
